// File: rtl/parking_pkg.sv
// parking_pkg: shared state type, default ID width and free-slot search for parking_gate_ctrl.
package parking_pkg;
    localparam int DEF_ID_W = 4;
    localparam int DEF_SLOTS = 2 ** DEF_ID_W;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENTRY_PULSE = 3'd1,
        ENTRY_GATE  = 3'd2,
        EXIT_PULSE  = 3'd3,
        EXIT_GATE   = 3'd4,
        REJECT      = 3'd5
    } gate_state_t;

    function automatic logic [DEF_ID_W-1:0] find_first_free(input logic [DEF_SLOTS-1:0] slots);
        logic [DEF_ID_W-1:0] idx;
        idx = '0;
        for (int i = DEF_SLOTS - 1; i >= 0; i--)
            if (!slots[i]) idx = DEF_ID_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: synchroniser, event qualifier and re-arm for one gate sensor.
// PARK_DEBOUNCE_EN selects the consecutive-high counter; otherwise the first synced-high clock qualifies.
module sensor_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic level;
    assign level = sync[SYNC_STAGES-1];
    // Resetting high means a sensor held across reset must drop before it can fire again
    always_ff @(posedge clk or negedge reset)
        if (!reset) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], sensor};
`ifdef PARK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic armed;
    assign pulse = armed && level && cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt <= '0;
            armed <= 1'b0;
        end else begin
            cnt <= !level ? '0 : (cnt == CW'(DEBOUNCE_CYCLES - 1) ? cnt : cnt + 1'b1);
            armed <= !level || (armed && !pulse);
        end
`else
    assign pulse = sync[SYNC_STAGES-2] && !level;
`endif
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: debounced gate sensors to serialised entry/exit events with ID allocation and gate timing.
// Build with PARK_DEBOUNCE_EN to require DEBOUNCE_CYCLES consecutive high clocks per sensor event.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int ID_W            = DEF_ID_W,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            entry_sensor,
    input  logic            exit_sensor,
    input  logic [ID_W-1:0] exit_car_id,
    output logic            entry,
    output logic            exit,
    output logic [ID_W-1:0] car_id,
    output logic            gate_in_open,
    output logic            gate_out_open,
    output logic            entry_reject,
    output logic            exit_reject,
    output logic [ID_W:0]   occupancy,
    output logic            full
);
    localparam int SLOTS = 2 ** ID_W;
    localparam int TW = $clog2(GATE_CYCLES + 1);

    logic entry_ev, exit_ev, entry_pend, exit_pend;
    logic [SLOTS-1:0] slots;
    logic [ID_W-1:0] free_id;
    logic [TW-1:0] timer;
    gate_state_t state;

    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
        .clk(clk), .reset(reset), .sensor(entry_sensor), .pulse(entry_ev)
    );
    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
        .clk(clk), .reset(reset), .sensor(exit_sensor), .pulse(exit_ev)
    );

    assign free_id = ID_W'(find_first_free(DEF_SLOTS'(slots)));
    assign full = occupancy == (ID_W + 1)'(SLOTS);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            {entry, exit, entry_reject, exit_reject, gate_in_open, gate_out_open} <= '0;
            {entry_pend, exit_pend} <= '0;
            car_id <= '0;
            occupancy <= '0;
            slots <= '0;
            timer <= '0;
        end else begin
            {entry, exit, entry_reject, exit_reject} <= '0;
            entry_pend <= entry_pend || entry_ev;
            exit_pend <= exit_pend || exit_ev;
            case (state)
                IDLE:
                    if (exit_pend) begin
                        state <= EXIT_PULSE;
                        exit_pend <= exit_ev;
                    end else if (entry_pend) begin
                        state <= ENTRY_PULSE;
                        entry_pend <= entry_ev;
                    end
                ENTRY_PULSE:
                    if (full) begin
                        entry_reject <= 1'b1;
                        state <= REJECT;
                    end else begin
                        entry <= 1'b1;
                        car_id <= free_id;
                        slots[free_id] <= 1'b1;
                        occupancy <= occupancy + 1'b1;
                        gate_in_open <= 1'b1;
                        timer <= TW'(GATE_CYCLES - 1);
                        state <= ENTRY_GATE;
                    end
                EXIT_PULSE:
                    if (slots[exit_car_id]) begin
                        exit <= 1'b1;
                        car_id <= exit_car_id;
                        slots[exit_car_id] <= 1'b0;
                        occupancy <= occupancy == '0 ? occupancy : occupancy - 1'b1;
                        gate_out_open <= 1'b1;
                        timer <= TW'(GATE_CYCLES - 1);
                        state <= EXIT_GATE;
                    end else begin
                        exit_reject <= 1'b1;
                        state <= REJECT;
                    end
                ENTRY_GATE, EXIT_GATE:
                    if (timer == '0) begin
                        gate_in_open <= 1'b0;
                        gate_out_open <= 1'b0;
                        state <= IDLE;
                    end else timer <= timer - 1'b1;
                default: state <= IDLE;
            endcase
        end
endmodule
